prog_ctrl: RTL and testbench

Writable program store plus run-control sequencer for the 4-bit CPU core. Replaces the fixed instruction ROM with a 16x8 RAM, loadable over a valid/ready byte stream. Gates the core through a clock-enable and a core-reset, supporting halt, run, single-step and one address breakpoint. Sits between the host/debug interface and the core's fetch path; presents the same opecode/imm read interface the core already uses.

---
 rtl/prog_ctrl_pkg.sv | 22 ++
 rtl/prog_ram.sv | 32 +++
 rtl/prog_ctrl.sv | 82 ++++++++
 tb/tb_prog_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctrl_pkg.sv
// prog_ctrl_pkg: shared program-store sizes, run-control states and core opcode constants
package prog_ctrl_pkg;
    localparam int PROG_DEPTH = 16;
    localparam int PROG_AW    = 4;
    localparam int OPC_W      = 4;
    localparam int IMM_W      = 4;
    localparam logic [OPC_W-1:0] ADD_A_IMM = 4'b0000;
    localparam logic [OPC_W-1:0] MOV_A_IMM = 4'b0011;
    localparam logic [OPC_W-1:0] ADD_B_IMM = 4'b0101;
    localparam logic [OPC_W-1:0] IN_B      = 4'b0110;
    localparam logic [OPC_W-1:0] OUT_B     = 4'b1001;
    localparam logic [OPC_W-1:0] OUT_IMM   = 4'b1011;
    localparam logic [OPC_W-1:0] JNC       = 4'b1110;
    localparam logic [OPC_W-1:0] JMP       = 4'b1111;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HALT = 3'd2,
        ST_RUN  = 3'd3,
        ST_STEP = 3'd4
    } state_e;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: program word store with synchronous write, reset clear and asynchronous read
module prog_ram
    import prog_ctrl_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int AW    = PROG_AW,
    parameter int DW    = OPC_W + IMM_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

    // reads see pre-write contents when the same word is written this cycle
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/prog_ctrl.sv
// prog_ctrl: loadable program store plus halt/run/step/breakpoint sequencer for the core
module prog_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int AW    = PROG_AW,
    parameter int DW    = OPC_W + IMM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [DW-1:0]    load_data,
    output logic             load_done,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    input  logic [AW-1:0]    cpu_addr,
    output logic [OPC_W-1:0] opecode,
    output logic [IMM_W-1:0] imm,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [2:0]       state_o
);
    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          done_q, done_d, first_q, first_d, we, bp_hit;
    logic [DW-1:0] rdata;

    always_comb begin
        load_ready = state_q == ST_LOAD;
        we         = load_ready && load_valid;
        // first RUN cycle skips the breakpoint so resuming executes the stopped instruction
        bp_hit     = state_q == ST_RUN && bp_en && cpu_addr == bp_addr && !first_q;
        cpu_en     = state_q == ST_STEP || (state_q == ST_RUN && !halt_req && !bp_hit);
        cpu_rst    = state_q == ST_IDLE || state_q == ST_LOAD;
        wr_ptr_d   = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
        done_d     = we && wr_ptr_q == AW'(DEPTH - 1);
        first_d    = state_q == ST_HALT && !load_start && !step && run;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: state_d = load_start ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = done_d ? ST_HALT : ST_LOAD;
            ST_HALT: state_d = load_start ? ST_LOAD : step ? ST_STEP : run ? ST_RUN : ST_HALT;
            ST_STEP: state_d = ST_HALT;
            ST_RUN:  state_d = (halt_req || bp_hit) ? ST_HALT : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
            first_q  <= first_d;
        end
    end

    prog_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .raddr (cpu_addr),
        .rdata (rdata)
    );

    assign opecode   = rdata[DW-1 -: OPC_W];
    assign imm       = rdata[IMM_W-1:0];
    assign load_done = done_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_prog_ctrl.sv
// tb_prog_ctrl: scoreboard bench for prog_ctrl against a behavioural model of the run-control rules
module tb_prog_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       load_start = 1'b0, load_valid = 1'b0, run = 1'b0, step = 1'b0, halt_req = 1'b0, bp_en = 1'b0;
    logic [7:0] load_data = '0;
    logic [3:0] bp_addr = '0, cpu_addr = '0;
    logic       load_ready, load_done, cpu_en, cpu_rst;
    logic [3:0] opecode, imm;
    logic [2:0] state_o;

    prog_ctrl dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .load_done(load_done),
        .run(run), .step(step), .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_addr(cpu_addr), .opecode(opecode), .imm(imm), .cpu_en(cpu_en),
        .cpu_rst(cpu_rst), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_LOAD = 1, M_HALT = 2, M_RUN = 3, M_STEP = 4;

    typedef struct packed {
        logic       en;
        logic       crst;
        logic       rdy;
        logic       done;
        logic [2:0] st;
        logic [3:0] opc;
        logic [3:0] imm;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0, n_fail = 0, cyc_n = 0;
    int         m_mode, m_cnt;
    logic [7:0] m_mem [16];
    bit         m_done, m_resume, use_pc;
    logic [3:0] pc = '0;

    function automatic void chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_n, got, exp);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin : mon
            exp_t e;
            e = q.pop_front();
            chk("cpu_en", cpu_en, e.en);
            chk("cpu_rst", cpu_rst, e.crst);
            chk("load_ready", load_ready, e.rdy);
            chk("load_done", load_done, e.done);
            chk("state_o", state_o, e.st);
            chk("opecode", opecode, e.opc);
            chk("imm", imm, e.imm);
        end
    end

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt = 0;
        m_done = 0;
        m_resume = 0;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
    endtask

    // one clock: predict this cycle's outputs from the model, then advance the model
    task automatic cyc();
        exp_t e;
        bit   bp, nd, nr;
        if (use_pc) cpu_addr = pc;
        bp = m_mode == M_RUN && bp_en && cpu_addr == bp_addr && !m_resume;
        e.en   = m_mode == M_STEP || (m_mode == M_RUN && !halt_req && !bp);
        e.crst = m_mode == M_IDLE || m_mode == M_LOAD;
        e.rdy  = m_mode == M_LOAD;
        e.done = m_done;
        e.st   = 3'(m_mode);
        {e.opc, e.imm} = m_mem[cpu_addr];
        q.push_back(e);
        nd = 0;
        nr = 0;
        if (rst) model_reset();
        else begin
            if (m_mode == M_IDLE && load_start) m_mode = M_LOAD;
            else if (m_mode == M_LOAD && load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (m_cnt == 16) begin
                    m_cnt = 0;
                    m_mode = M_HALT;
                    nd = 1;
                end
            end else if (m_mode == M_HALT) begin
                if (load_start) m_mode = M_LOAD;
                else if (step) m_mode = M_STEP;
                else if (run) begin
                    m_mode = M_RUN;
                    nr = 1;
                end
            end else if (m_mode == M_STEP) m_mode = M_HALT;
            else if (m_mode == M_RUN && (halt_req || bp)) m_mode = M_HALT;
            m_done = nd;
            m_resume = nr;
        end
        if (use_pc && e.en) pc = pc + 4'd1;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        int sent;
        logic [3:0] iv;
        sent = 0;
        for (int c = 0; c < 200 && sent < n; c++) begin
            load_valid = (c % 3) != 2;
            iv = sent[3:0];
            load_data = {iv, ~iv};
            if (load_valid) sent++;
            cyc();
        end
        load_valid = 0;
        chk("stream_sent", sent, n);
    endtask

    task automatic readback();
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 4'(i);
            cyc();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        use_pc = 0;
        repeat (5) cyc();
        readback();
        load_start = 1;
        cyc();
        stream(16);
        load_start = 0;
        cpu_addr = 4'd5;
        repeat (3) cyc();
        readback();
        repeat (3) begin
            step = 1;
            cyc();
            step = 0;
            repeat (3) cyc();
        end
        use_pc = 1;
        pc = 4'd0;
        bp_en = 1;
        bp_addr = 4'd7;
        run = 1;
        cyc();
        run = 0;
        repeat (12) cyc();
        run = 1;
        cyc();
        run = 0;
        repeat (4) cyc();
        halt_req = 1;
        cyc();
        halt_req = 0;
        cyc();
        bp_addr = pc + 4'd3;
        run = 1;
        cyc();
        run = 0;
        repeat (8) begin
            halt_req = pc == bp_addr && m_mode == M_RUN;
            cyc();
        end
        halt_req = 0;
        bp_en = 0;
        use_pc = 0;
        load_start = 1;
        cyc();
        load_start = 0;
        stream(8);
        rst = 1;
        cyc();
        rst = 0;
        readback();
        load_start = 1;
        cyc();
        load_start = 0;
        stream(16);
        readback();
        use_pc = 1;
        repeat (3000) begin
            rst        = ($urandom % 400) == 0;
            load_start = ($urandom % 24) == 0;
            load_valid = ($urandom % 4) != 0;
            load_data  = 8'($urandom);
            run        = ($urandom % 6) == 0;
            step       = ($urandom % 6) == 0;
            halt_req   = ($urandom % 12) == 0;
            bp_en      = ($urandom % 2) == 0;
            if (($urandom % 32) == 0) bp_addr = 4'($urandom);
            if (($urandom % 8) == 0) pc = 4'($urandom);
            cyc();
        end
        rst = 0;
        load_start = 0;
        load_valid = 0;
        run = 0;
        step = 0;
        halt_req = 0;
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
